dma_mem_responder: RTL and testbench

- Responder end of the per-core DMA arbiter bus (req/we/addr/wdata -> gnt/valid/rdata) driven by each NTT core's LOAD/STORE/LOAD_W/CONFIG sequencers.
- Arbitrates NUM_CORES initiators round-robin and serves them from a single-port 64-bit backing store.
- Writes commit on grant; read data returns READ_LAT cycles after grant as a one-cycle valid pulse to the requester.
- Sits between the core array and on-chip polynomial/twiddle/config memory.

---
 rtl/fhe_mem_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/dma_mem_responder.sv | 108 ++++++++++
 tb/tb_dma_mem_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fhe_mem_pkg.sv
// Shared widths and address decode for the DMA memory responder.
package fhe_mem_pkg;

  localparam int ADDR_W     = 48;
  localparam int DATA_W     = 64;
  localparam int WORD_SHIFT = 3;
  localparam int IDX_W      = ADDR_W - WORD_SHIFT;

  typedef struct packed {
    logic             ok;
    logic [IDX_W-1:0] idx;
  } addr_dec_t;

  function automatic addr_dec_t decode_addr(
    input logic [ADDR_W-1:0] addr,
    input int                dlog
  );
    addr_dec_t d;
    d.idx = addr[ADDR_W-1:WORD_SHIFT];
    d.ok  = (addr >> (dlog + WORD_SHIFT)) == '0;
    return d;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant,
// pointer moves past the winner on every grant.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic          found;

  always_comb begin
    int c;
    c       = 0;
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int o = 0; o < N; o++) begin
      c = int'(ptr) + o;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt_idx = IW'(c);
      end
    end
    if (!rst && found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dma_mem_responder.sv
// DMA bus responder: RR arbitration over a single-port
// 64-bit store with a fixed-latency read-return pipeline.
module dma_mem_responder
  import fhe_mem_pkg::*;
#(
  parameter  int NUM_CORES = 2,
  parameter  int DEPTH_LOG = 15,
  parameter  int READ_LAT  = 1,
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        arb_req,
  input  logic [NUM_CORES-1:0]        arb_we,
  input  logic [NUM_CORES*ADDR_W-1:0] arb_addr,
  input  logic [NUM_CORES*DATA_W-1:0] arb_wdata,
  output logic [NUM_CORES-1:0]        arb_gnt,
  output logic [NUM_CORES-1:0]        arb_valid,
  output logic [NUM_CORES*DATA_W-1:0] arb_rdata,
  output logic                        err_oob,
  output logic [31:0]                 grant_count
);

  logic [IW-1:0]        gidx;
  logic                 gany;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_we;
  addr_dec_t            dec;
  logic [DEPTH_LOG-1:0] widx;
  logic [DATA_W-1:0]    rd_word;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG];

  logic              pv  [READ_LAT];
  logic [IW-1:0]     pid [READ_LAT];
  logic [DATA_W-1:0] pd  [READ_LAT];
  logic              nv  [READ_LAT];
  logic [IW-1:0]     nid [READ_LAT];
  logic [DATA_W-1:0] nd  [READ_LAT];

  logic [DATA_W-1:0] rdata_q [NUM_CORES];

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .gnt     (arb_gnt),
    .gnt_idx (gidx)
  );

  assign gany      = |arb_gnt;
  assign sel_addr  = arb_addr[int'(gidx)*ADDR_W +: ADDR_W];
  assign sel_wdata = arb_wdata[int'(gidx)*DATA_W +: DATA_W];
  assign sel_we    = arb_we[gidx];
  assign dec       = decode_addr(sel_addr, DEPTH_LOG);
  assign widx      = DEPTH_LOG'(dec.idx);
  assign rd_word   = dec.ok ? mem[widx] : '0;

  always_ff @(posedge clk) begin
    if (gany && sel_we && dec.ok) mem[widx] <= sel_wdata;
  end

  // Stage 0 is loaded at the grant edge; the last stage drives valid.
  always_comb begin
    nv[0]  = gany && !sel_we;
    nid[0] = gidx;
    nd[0]  = rd_word;
    for (int k = 1; k < READ_LAT; k++) begin
      nv[k]  = pv[k-1];
      nid[k] = pid[k-1];
      nd[k]  = pd[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LAT; k++) pv[k] <= 1'b0;
      for (int c = 0; c < NUM_CORES; c++) rdata_q[c] <= '0;
    end else begin
      for (int k = 0; k < READ_LAT; k++) begin
        pv[k]  <= nv[k];
        pid[k] <= nid[k];
        pd[k]  <= nd[k];
      end
      if (nv[READ_LAT-1])
        rdata_q[nid[READ_LAT-1]] <= nd[READ_LAT-1];
    end
  end

  always_comb begin
    arb_valid = '0;
    if (!rst && pv[READ_LAT-1]) arb_valid[pid[READ_LAT-1]] = 1'b1;
    for (int c = 0; c < NUM_CORES; c++)
      arb_rdata[c*DATA_W +: DATA_W] = rdata_q[c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob     <= 1'b0;
      grant_count <= '0;
    end else if (gany) begin
      grant_count <= grant_count + 32'd1;
      if (!dec.ok) err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: vector table
// plus hand sequences for streaming, OOB and reset.
module tb_dma_mem_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   arb_req = '0;
  logic [1:0]   arb_we = '0;
  logic [95:0]  arb_addr = '0;
  logic [127:0] arb_wdata = '0;
  logic [1:0]   arb_gnt;
  logic [1:0]   arb_valid;
  logic [127:0] arb_rdata;
  logic         err_oob;
  logic [31:0]  grant_count;

  int n_chk = 0;
  int n_fail = 0;

  dma_mem_responder #(
    .NUM_CORES(2), .DEPTH_LOG(15), .READ_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .arb_req(arb_req), .arb_we(arb_we),
    .arb_addr(arb_addr), .arb_wdata(arb_wdata),
    .arb_gnt(arb_gnt), .arb_valid(arb_valid),
    .arb_rdata(arb_rdata), .err_oob(err_oob),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [47:0] a0, a1;
    logic [63:0] d0, d1;
    logic [1:0]  gnt;
    logic [1:0]  valid;
    logic [63:0] r0, r1;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [47:0] a0, input logic [47:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1);
    arb_req   = req;
    arb_we    = we;
    arb_addr  = {a1, a0};
    arb_wdata = {d1, d0};
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bad;
    logic [63:0] k;
    k = 64'hDEADBEEF_00000001;
    vt[0]  = '{2'b01, 2'b01, 48'h100, 48'h0, k, 64'h0,
               2'b01, 2'b00, 64'h0, 64'h0};
    vt[1]  = '{2'b01, 2'b00, 48'h100, 48'h0, 64'h0, 64'h0,
               2'b01, 2'b00, 64'h0, 64'h0};
    vt[2]  = '{2'b00, 2'b00, 48'h0, 48'h0, 64'h0, 64'h0,
               2'b00, 2'b01, k, 64'h0};
    vt[3]  = '{2'b00, 2'b00, 48'h0, 48'h0, 64'h0, 64'h0,
               2'b00, 2'b00, k, 64'h0};
    vt[4]  = '{2'b01, 2'b01, 48'h18, 48'h0,
               64'h1111_2222_3333_4444, 64'h0,
               2'b01, 2'b00, k, 64'h0};
    vt[5]  = '{2'b01, 2'b00, 48'h1F, 48'h0, 64'h0, 64'h0,
               2'b01, 2'b00, k, 64'h0};
    vt[6]  = '{2'b11, 2'b11, 48'h200, 48'h208, 64'hAAAA, 64'hBBBB,
               2'b10, 2'b01, 64'h1111_2222_3333_4444, 64'h0};
    vt[7]  = '{2'b11, 2'b11, 48'h200, 48'h208, 64'hAAAA, 64'hBBBB,
               2'b01, 2'b00, 64'h1111_2222_3333_4444, 64'h0};
    vt[8]  = '{2'b11, 2'b00, 48'h208, 48'h200, 64'h0, 64'h0,
               2'b10, 2'b00, 64'h1111_2222_3333_4444, 64'h0};
    vt[9]  = '{2'b11, 2'b00, 48'h208, 48'h200, 64'h0, 64'h0,
               2'b01, 2'b10, 64'h1111_2222_3333_4444, 64'hAAAA};
    vt[10] = '{2'b00, 2'b00, 48'h0, 48'h0, 64'h0, 64'h0,
               2'b00, 2'b01, 64'hBBBB, 64'hAAAA};
    vt[11] = '{2'b00, 2'b00, 48'h0, 48'h0, 64'h0, 64'h0,
               2'b00, 2'b00, 64'hBBBB, 64'hAAAA};

    // Reset state, with requests pending during rst.
    drive(2'b11, 2'b00, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 64'(arb_gnt), 64'h0);
    chk("rst_valid", 64'(arb_valid), 64'h0);
    chk("rst_rdata0", arb_rdata[63:0], 64'h0);
    chk("rst_rdata1", arb_rdata[127:64], 64'h0);
    chk("rst_err", 64'(err_oob), 64'h0);
    chk("rst_count", 64'(grant_count), 64'h0);
    idle();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vt[i].req, vt[i].we, vt[i].a0, vt[i].a1,
            vt[i].d0, vt[i].d1);
      #1;
      chk($sformatf("v%0d_gnt", i), 64'(arb_gnt), 64'(vt[i].gnt));
      chk($sformatf("v%0d_valid", i), 64'(arb_valid),
          64'(vt[i].valid));
      chk($sformatf("v%0d_r0", i), arb_rdata[63:0], vt[i].r0);
      chk($sformatf("v%0d_r1", i), arb_rdata[127:64], vt[i].r1);
    end
    @(negedge clk);
    idle();
    #1;
    chk("table_count", 64'(grant_count), 64'd8);
    chk("table_err", 64'(err_oob), 64'h0);

    // Contention from reset: strict alternation.
    @(negedge clk);
    rst = 1'b1;
    drive(2'b11, 2'b00, 48'h40, 48'h40, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d_gnt", i), 64'(arb_gnt),
          (i % 2 == 0) ? 64'h1 : 64'h2);
      @(negedge clk);
    end
    idle();
    #1;
    chk("cont_count", 64'(grant_count), 64'd4);

    // Streamed store from core1.
    do_reset();
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      drive(2'b10, 2'b10, '0, 48'(i * 8), '0, 64'(i));
      #1;
      if (arb_gnt !== 2'b10) bad++;
      @(negedge clk);
    end
    chk("stream_gnt_errs", 64'(bad), 64'h0);
    drive(2'b01, 2'b00, 48'h7FF8, '0, '0, '0);
    #1;
    chk("stream_rd_gnt", 64'(arb_gnt), 64'h1);
    @(negedge clk);
    idle();
    #1;
    chk("stream_rd_valid", 64'(arb_valid), 64'h1);
    chk("stream_rd_data", arb_rdata[63:0], 64'd4095);
    chk("stream_count", 64'(grant_count), 64'd4097);

    // Out-of-range write and read.
    @(negedge clk);
    drive(2'b01, 2'b01, 48'h0, '0, 64'h5555, '0);
    @(negedge clk);
    drive(2'b01, 2'b01, 48'h0001_0000_0000, '0, 64'hFFFF, '0);
    #1;
    chk("oob_pre_err", 64'(err_oob), 64'h0);
    chk("oob_wr_gnt", 64'(arb_gnt), 64'h1);
    @(negedge clk);
    drive(2'b01, 2'b00, 48'h0001_0000_0000, '0, '0, '0);
    #1;
    chk("oob_wr_err", 64'(err_oob), 64'h1);
    chk("oob_rd_gnt", 64'(arb_gnt), 64'h1);
    @(negedge clk);
    drive(2'b01, 2'b00, 48'h0, '0, '0, '0);
    #1;
    chk("oob_rd_valid", 64'(arb_valid), 64'h1);
    chk("oob_rd_data", arb_rdata[63:0], 64'h0);
    @(negedge clk);
    idle();
    #1;
    chk("oob_w0_valid", 64'(arb_valid), 64'h1);
    chk("oob_w0_data", arb_rdata[63:0], 64'h5555);
    repeat (100) @(negedge clk);
    #1;
    chk("oob_sticky", 64'(err_oob), 64'h1);

    // Reset while a read is in flight.
    @(negedge clk);
    drive(2'b01, 2'b00, 48'h0, '0, '0, '0);
    #1;
    chk("mid_gnt", 64'(arb_gnt), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    drive(2'b11, 2'b00, '0, '0, '0, '0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (arb_valid !== 2'b00) bad++;
      if (arb_gnt !== 2'b00) bad++;
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (arb_valid !== 2'b00) bad++;
      @(negedge clk);
    end
    chk("mid_no_valid", 64'(bad), 64'h0);
    chk("mid_count", 64'(grant_count), 64'h0);
    chk("mid_err", 64'(err_oob), 64'h0);
    chk("mid_rdata0", arb_rdata[63:0], 64'h0);
    drive(2'b01, 2'b00, 48'h0, '0, '0, '0);
    @(negedge clk);
    idle();
    #1;
    chk("mid_fresh_valid", 64'(arb_valid), 64'h1);
    chk("mid_fresh_data", arb_rdata[63:0], 64'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
